// File: rtl/dmem_lsu.sv
// Load/store unit between the RV32I memory stage and a 1-cycle-latency word RAM.
// One request in flight; stores/errors answer in T+1, loads in T+2.

module dmem_lsu_lane #(
    parameter int IDX = 0
) (
    input  logic [2:0]  f3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic        mask,
    output logic [7:0]  data
);
    localparam logic [1:0] LANE = 2'(IDX);

    always_comb begin
        mask = 1'b0;
        data = wdata[8*IDX +: 8];
        case (f3[1:0])
            2'b00: begin
                mask = (off == LANE);
                data = wdata[7:0];
            end
            2'b01: begin
                mask = (off[1] == LANE[1]);
                data = wdata[8*(IDX%2) +: 8];
            end
            2'b10: mask = 1'b1;
            default: mask = 1'b0;
        endcase
    end
endmodule

module dmem_lsu #(
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH*4)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [2:0]    req_funct3_i,
    input  logic [31:0]   req_addr_i,
    input  logic [31:0]   req_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wr_data_o,
    output logic [3:0]    mem_bytemask_o,
    output logic          mem_write_en_o,
    output logic          mem_read_en_o,
    input  logic [31:0]   mem_rd_data_i
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    state_t      state, state_nx;
    rsp_t        rsp_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        hs, err, misal, oor, bad_f3;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign misal  = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                    (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
    assign oor    = (req_addr_i >= 32'(DEPTH*4));
    assign bad_f3 = req_we_i ? (req_funct3_i[2] || req_funct3_i[1:0] == 2'b11)
                             : (req_funct3_i[1:0] == 2'b11 || req_funct3_i == 3'b110);
    assign err    = misal || oor || bad_f3;
    assign hs     = req_valid_i && req_ready_o;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        dmem_lsu_lane #(.IDX(i)) u_lane (
            .f3    (req_funct3_i),
            .off   (req_addr_i[1:0]),
            .wdata (req_wdata_i),
            .mask  (lane_mask[i]),
            .data  (lane_data[8*i +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs) state_nx = (req_we_i || err) ? RESP : RD_WAIT;
            RD_WAIT: state_nx = RESP;
            RESP:    if (rsp_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o    = (state == IDLE) && !rst_i;
        rsp_valid_o    = (state == RESP);
        rsp_rdata_o    = rsp_q.rdata;
        rsp_err_o      = rsp_q.err;
        mem_addr_o     = req_addr_i[AW-1:0];
        mem_wr_data_o  = lane_data;
        mem_write_en_o = hs && !err && req_we_i;
        mem_read_en_o  = hs && !err && !req_we_i;
        mem_bytemask_o = mem_write_en_o ? lane_mask : 4'b0000;
    end

    // Offset and funct3 are latched at acceptance; RAM data arrives one cycle later.
    assign rd_byte = mem_rd_data_i[{off_q, 3'b000} +: 8];
    assign rd_half = mem_rd_data_i[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'h0, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'h0, rd_half};
            default: rd_ext = mem_rd_data_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rsp_q <= '0;
            off_q <= '0;
            f3_q  <= '0;
        end else if (state == IDLE && hs) begin
            off_q <= req_addr_i[1:0];
            f3_q  <= req_funct3_i;
            rsp_q <= '{rdata: 32'h0, err: err};
        end else if (state == RD_WAIT) begin
            rsp_q <= '{rdata: rd_ext, err: 1'b0};
        end
    end
endmodule
